gate_bank_sweeper: RTL and testbench

//  Parametrised bank of N_CH two-input logic gates with a per-channel opcode and

---
 rtl/gate_bank_sweeper.sv | 157 +++++++++++++++
 tb/tb_gate_bank_sweeper.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bank_sweeper.sv
// Bank of N_CH two-input gates with per-channel opcodes and registered outputs.
// A sweep FSM drives all four {A,B} vectors and compares y against an independent truth table.
module gate_bank_sweeper #(
  parameter int N_CH     = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              start,
  input  logic [3*N_CH-1:0] op_sel,
  input  logic [N_CH-1:0]   a,
  input  logic [N_CH-1:0]   b,
  input  logic [N_CH-1:0]   fault_inj,
  output logic [N_CH-1:0]   y,
  output logic [1:0]        vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_CH-1:0]   fail_mask
);
  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     hold_cnt_reg, hold_cnt_next;
  logic [1:0]        vec_reg, vec_next;
  logic [3*N_CH-1:0] op_lat_reg, op_lat_next;
  logic [N_CH-1:0]   y_reg, y_next;
  logic [N_CH-1:0]   fail_reg, fail_next;
  logic [N_CH-1:0]   gate_out, golden_out;
  logic              launch;

  function automatic logic gate_fn(input logic [2:0] op, input logic ga, input logic gb);
    logic r;
    case (op)
      3'd0:    r = ga & gb;
      3'd1:    r = ga | gb;
      3'd2:    r = ~(ga & gb);
      3'd3:    r = ~(ga | gb);
      3'd4:    r = ga ^ gb;
      3'd5:    r = ~(ga ^ gb);
      3'd6:    r = ~ga;
      default: r = ga;
    endcase
    return r;
  endfunction

  // Reference truth tables, bit index = {A,B}; deliberately separate from gate_fn.
  function automatic logic golden_fn(input logic [2:0] op, input logic [1:0] ab);
    logic [3:0] tt;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0111;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0110;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    return tt[ab];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [2:0] op_live;
      logic [2:0] op_held;
      assign op_live = op_sel[3*gi +: 3];
      assign op_held = op_lat_reg[3*gi +: 3];
      assign gate_out[gi] = (state_reg == IDLE) ? gate_fn(op_live, a[gi], b[gi])
                                                : gate_fn(op_held, vec_reg[1], vec_reg[0]);
      assign golden_out[gi] = golden_fn(op_held, vec_reg);
    end
  endgenerate

  assign launch = start && mode;

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    vec_next      = vec_reg;
    op_lat_next   = op_lat_reg;
    y_next        = y_reg;
    fail_next     = fail_reg;
    case (state_reg)
      IDLE: begin
        y_next = gate_out ^ fault_inj;
        if (launch) begin
          state_next    = APPLY;
          vec_next      = 2'd0;
          fail_next     = '0;
          op_lat_next   = op_sel;
          hold_cnt_next = '0;
        end
      end
      APPLY: begin
        y_next = gate_out ^ fault_inj;
        if (hold_cnt_reg == CW'(HOLD_CYC - 1)) begin
          state_next    = CHECK;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      CHECK: begin
        fail_next = fail_reg | (y_reg ^ golden_out);
        if (vec_reg == 2'd3) begin
          state_next = DONE;
        end else begin
          vec_next   = vec_reg + 2'd1;
          state_next = APPLY;
        end
      end
      DONE: begin
        // Leaving to manual mode takes priority over a restart request.
        if (!mode) begin
          state_next = IDLE;
        end else if (start) begin
          state_next    = APPLY;
          vec_next      = 2'd0;
          fail_next     = '0;
          op_lat_next   = op_sel;
          hold_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      vec_reg      <= 2'd0;
      op_lat_reg   <= '0;
      y_reg        <= '0;
      fail_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      vec_reg      <= vec_next;
      op_lat_reg   <= op_lat_next;
      y_reg        <= y_next;
      fail_reg     <= fail_next;
    end
  end

  assign y         = y_reg;
  assign vec       = vec_reg;
  assign fail_mask = fail_reg;
  assign busy      = (state_reg == APPLY) || (state_reg == CHECK);
  assign done      = (state_reg == DONE);
  assign pass      = done && (fail_reg == '0);
endmodule

// File: tb/tb_gate_bank_sweeper.sv
// Scoreboard bench for gate_bank_sweeper: stimulus pushes expectations, a negedge monitor
// pops them when y is due (manual mode) or when done rises (sweep).
module tb_gate_bank_sweeper;
  localparam int N_CH = 8;
  localparam int HOLD_CYC = 2;
  localparam int SWEEP_CYC = 4 * (HOLD_CYC + 1);

  logic        clk, rst_n, mode, start;
  logic [23:0] op_sel;
  logic [7:0]  a, b, fault_inj;
  logic [7:0]  y, fail_mask;
  logic [1:0]  vec;
  logic        busy, done, pass;

  gate_bank_sweeper #(.N_CH(N_CH), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .op_sel(op_sel),
    .a(a), .b(b), .fault_inj(fault_inj), .y(y), .vec(vec), .busy(busy),
    .done(done), .pass(pass), .fail_mask(fail_mask)
  );

  typedef struct { int due; logic [7:0] y; } man_t;
  typedef struct { int due; logic [7:0] fm; logic ps; logic [7:0] y; } sw_t;

  man_t man_q[$];
  sw_t  sw_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   bcount = 0;
  logic [7:0] vlog = 8'h0;
  logic [1:0] vprev = 2'd0;
  logic       done_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each gate as integer arithmetic on 0/1 operands.
  function automatic logic [7:0] model(input logic [23:0] ops, input logic [7:0] av,
                                        input logic [7:0] bv, input logic [7:0] f);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      int x, z, o, v;
      x = int'(av[i]);
      z = int'(bv[i]);
      o = int'(ops[3*i +: 3]);
      case (o)
        0:       v = x * z;
        1:       v = x + z - x * z;
        2:       v = 1 - x * z;
        3:       v = 1 - (x + z - x * z);
        4:       v = (x + z) % 2;
        5:       v = 1 - (x + z) % 2;
        6:       v = 1 - x;
        default: v = x;
      endcase
      r[i] = v[0] ^ f[i];
    end
    return r;
  endfunction

  // Monitor
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      bcount = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) begin
        if (bcount == 0) vlog = {6'd0, vec};
        else if (vec != vprev) vlog = {vlog[5:0], vec};
        vprev = vec;
        bcount++;
      end
      if (done && !done_prev) begin
        if (sw_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          sw_t s;
          s = sw_q.pop_front();
          $display("sweep done at cycle %0d: fail_mask=%02h pass=%0b y=%02h", cyc, fail_mask, pass, y);
          check("sweep_fail_mask", 32'(fail_mask), 32'(s.fm));
          check("sweep_pass", 32'(pass), 32'(s.ps));
          check("sweep_y_hold", 32'(y), 32'(s.y));
          check("sweep_done_cycle", 32'(cyc), 32'(s.due));
          check("sweep_busy_cycles", 32'(bcount), 32'(SWEEP_CYC));
          check("sweep_vec_steps", 32'(vlog), 32'h1B);
        end
        bcount = 0;
      end
      done_prev = done;
      if (man_q.size() > 0) begin
        if (man_q[0].due == cyc) begin
          man_t m;
          m = man_q.pop_front();
          $display("manual cycle %0d: y=%02h busy=%0b done=%0b", cyc, y, busy, done);
          check("manual_y", 32'(y), 32'(m.y));
          check("manual_busy", 32'(busy), 32'd0);
          check("manual_done", 32'(done), 32'd0);
        end else if (man_q[0].due < cyc) begin
          void'(man_q.pop_front());
          check("manual_missed", 32'd1, 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic manual(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] f,
                        input bit st, input bit use_exp, input logic [7:0] exp);
    man_t m;
    a = av; b = bv; fault_inj = f; mode = 1'b0; start = st;
    m.due = cyc + 1;
    m.y = use_exp ? exp : model(op_sel, av, bv, f);
    man_q.push_back(m);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 30 && (sw_q.size() > 0 || man_q.size() > 0); w++) tick();
    if (sw_q.size() > 0 || man_q.size() > 0) begin
      check("drain_timeout", 32'(sw_q.size() + man_q.size()), 32'd0);
      sw_q.delete();
      man_q.delete();
    end
  endtask

  task automatic sweep(input logic [23:0] ops, input logic [7:0] f, input bit noisy);
    sw_t s;
    op_sel = ops; fault_inj = f; mode = 1'b1; start = 1'b1;
    s.due = cyc + 1 + SWEEP_CYC;
    s.fm = f;
    s.ps = (f == 8'h00);
    s.y = model(ops, 8'hFF, 8'hFF, f);
    sw_q.push_back(s);
    tick();
    start = 1'b0;
    for (int i = 1; i < SWEEP_CYC; i++) begin
      if (noisy) begin
        op_sel = 24'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        start = (i == 4);
        mode = (i < SWEEP_CYC - 3) ? 1'($urandom) : 1'b1;
      end
      tick();
    end
    start = 1'b0;
    mode = 1'b1;
    drain();
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; start = 1'b0;
    op_sel = '0; a = '0; b = '0; fault_inj = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_y", 32'(y), 32'd0);
    check("reset_vec", 32'(vec), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_fail_mask", 32'(fail_mask), 32'd0);
    rst_n = 1'b1;
    tick();

    op_sel = 24'hFAC688;
    manual(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 8'h96);
    manual(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h6C);
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) op_sel = 24'($urandom);
      manual(8'($urandom), 8'($urandom), (i % 3 == 0) ? 8'($urandom) : 8'h00, 1'($urandom), 1'b0, 8'h00);
    end
    drain();

    op_sel = 24'hFAC688;
    sweep(24'hFAC688, 8'h00, 1'b0);
    sweep(24'hFAC688, 8'h08, 1'b0);

    mode = 1'b0;
    tick();
    check("done_exit_done", 32'(done), 32'd0);
    check("done_exit_busy", 32'(busy), 32'd0);
    check("done_exit_fail_kept", 32'(fail_mask), 32'h08);
    manual(8'h0F, 8'h33, 8'h00, 1'b0, 1'b0, 8'h00);
    drain();

    for (int k = 0; k < 8; k++) begin
      logic [23:0] ops;
      logic [7:0] f;
      ops = 24'($urandom);
      f = ($urandom_range(1, 0) == 1) ? 8'($urandom) : 8'h00;
      if ($urandom_range(1, 0) == 1) begin
        mode = 1'b0;
        tick();
      end
      sweep(ops, f, 1'b1);
    end

    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_mode0_done", 32'(done), 32'd0);
    check("done_start_mode0_busy", 32'(busy), 32'd0);
    manual(8'hA5, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h00);
    drain();

    op_sel = 24'hFAC688; fault_inj = 8'hFF; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_y", 32'(y), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_vec", 32'(vec), 32'd0);
    check("midreset_fail_mask", 32'(fail_mask), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    fault_inj = 8'h00; mode = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("postreset_busy", 32'(busy), 32'd0);
    manual(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 8'h96);
    manual(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h6C);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
